// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and constants for the keyboard path.
// Optional glitch filter in ps2_sync_filter is enabled by PS2_GLITCH_FILTER_EN.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2State_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  // Prefix bytes interpreted by the downstream decoder.
  localparam logic [7:0] PS2_BREAK_CODE    = 8'hF0;
  localparam logic [7:0] PS2_EXTENDED_CODE = 8'hE0;

  function automatic logic oddParityOk(input logic [7:0] dataByte, input logic parityBit);
    return ^{dataByte, parityBit};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// 2-FF synchronizers for the PS/2 pins plus ps2_clk falling-edge detect.
// With PS2_GLITCH_FILTER_EN defined, ps2_clk is debounced over FILTER_LEN samples first.
module ps2_sync_filter
`ifdef PS2_GLITCH_FILTER_EN
  #(parameter int FILTER_LEN = 8)
`endif
(
  input  logic clk,
  input  logic resetn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fe,
  output logic dataS
);

  logic [1:0] clkSync;
  logic [1:0] dataSync;
  logic       edgeSrc;
  logic       edgePrev;

  // Idle bus is high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
    end else begin
      clkSync  <= {clkSync[0], ps2_clk};
      dataSync <= {dataSync[0], ps2_data};
    end
  end

  assign dataS = dataSync[1];

`ifdef PS2_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] filtCnt;
  logic          filtClk;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filtClk <= 1'b1;
      filtCnt <= '0;
    end else if (clkSync[1] == filtClk) begin
      filtCnt <= '0;
    end else if (filtCnt == CW'(FILTER_LEN - 1)) begin
      filtClk <= clkSync[1];
      filtCnt <= '0;
    end else begin
      filtCnt <= filtCnt + CW'(1);
    end
  end

  assign edgeSrc = filtClk;
`else
  assign edgeSrc = clkSync[1];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) edgePrev <= 1'b1;
    else         edgePrev <= edgeSrc;
  end

  assign fe = edgePrev & ~edgeSrc;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start/8 data/odd parity/stop with stall timeout.
// PS2_GLITCH_FILTER_EN adds a FILTER_LEN-sample ps2_clk glitch filter ahead of edge detect.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
`ifdef PS2_GLITCH_FILTER_EN
  , parameter int FILTER_LEN = 8
`endif
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code_out,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(PS2_DATA_BITS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          fe;
  logic          dataS;
  ps2State_t     state, stateNext;
  logic [BW-1:0] bitCnt, bitCntNext;
  logic [7:0]    shreg, shregNext;
  logic          parityBit, parityNext;
  logic [TW-1:0] toCnt, toCntNext;
  logic [7:0]    codeNext;
  logic          validNext, parErrNext, frmErrNext;

  ps2_sync_filter
`ifdef PS2_GLITCH_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
  uSync (
    .clk     (clk),
    .resetn  (resetn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .fe      (fe),
    .dataS   (dataS)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      bitCnt     <= '0;
      shreg      <= '0;
      parityBit  <= 1'b0;
      toCnt      <= '0;
      code_out   <= 8'h00;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= stateNext;
      bitCnt     <= bitCntNext;
      shreg      <= shregNext;
      parityBit  <= parityNext;
      toCnt      <= toCntNext;
      code_out   <= codeNext;
      code_valid <= validNext;
      parity_err <= parErrNext;
      frame_err  <= frmErrNext;
    end
  end

  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt;
    shregNext  = shreg;
    parityNext = parityBit;
    codeNext   = code_out;
    validNext  = 1'b0;
    parErrNext = 1'b0;
    frmErrNext = 1'b0;

    if (fe || state == IDLE) toCntNext = '0;
    else if (toCnt != '1)    toCntNext = toCnt + TW'(1);
    else                     toCntNext = toCnt;

    if (fe) begin
      case (state)
        IDLE: begin
          // A falling edge with data high is a false start and is ignored.
          if (!dataS) begin
            stateNext  = DATA;
            bitCntNext = '0;
          end
        end
        DATA: begin
          shregNext  = {dataS, shreg[7:1]};
          bitCntNext = bitCnt + BW'(1);
          if (bitCnt == BW'(PS2_DATA_BITS - 1)) stateNext = PARITY;
        end
        PARITY: begin
          parityNext = dataS;
          stateNext  = STOP;
        end
        STOP: begin
          stateNext = IDLE;
          if (!dataS)                            frmErrNext = 1'b1;
          else if (!oddParityOk(shreg, parityBit)) parErrNext = 1'b1;
          else begin
            codeNext  = shreg;
            validNext = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end else if (state != IDLE && toCnt == TO_LAST) begin
      stateNext  = IDLE;
      shregNext  = '0;
      frmErrNext = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Randomized self-checking bench for ps2_rx_frame (PS2_GLITCH_FILTER_EN adds the glitch test).
// The PS/2 bit period is scaled down to keep simulation short.
module tb_ps2_rx_frame;
  import ps2_pkg::*;

  localparam int T = 300;
  localparam int H = 20;
`ifdef PS2_GLITCH_FILTER_EN
  localparam int LAT = 3 + 8;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code_out;
  logic       code_valid, parity_err, frame_err;

  int nCmp = 0, nErr = 0;
  int obsValid = 0, obsPar = 0, obsFrm = 0;
  int expValid = 0, expPar = 0, expFrm = 0;
  logic [7:0] expCode = 8'h00;

  ps2_rx_frame #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code_out  (code_out),
    .code_valid(code_valid),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Every cycle a strobe is high counts once, so a stuck strobe shows as extra pulses.
  always @(negedge clk) begin
    if (code_valid) obsValid <= obsValid + 1;
    if (parity_err) obsPar   <= obsPar + 1;
    if (frame_err)  obsFrm   <= obsFrm + 1;
  end

  task automatic sendBit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] fr;
    fr = {s, p, d, 1'b0};
    for (int i = 0; i < PS2_FRAME_BITS; i++) sendBit(fr[i]);
    repeat (H) @(negedge clk);
  endtask

  // Reference: stop bit first, then odd parity by population count.
  task automatic modelFrame(input logic [7:0] d, input logic p, input logic s);
    if (s == 1'b0) expFrm++;
    else if (($countones(d) + int'(p)) % 2 != 1) expPar++;
    else begin
      expValid++;
      expCode = d;
    end
  endtask

  function automatic logic goodParity(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic test_reset;
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    nCmp++; if (code_out !== 8'h00) begin nErr++; $display("FAIL reset_code got %h want 00", code_out); end
    nCmp++; if ({code_valid, parity_err, frame_err} !== 3'b000) begin
      nErr++; $display("FAIL reset_pulses got %b want 000", {code_valid, parity_err, frame_err});
    end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    $display("test_reset: code_out=%h", code_out);
  endtask

  task automatic test_single_latency;
    logic [10:0] fr;
    int lat;
    fr = {1'b1, 1'b0, 8'h1C, 1'b0};
    lat = -1;
    for (int i = 0; i < PS2_FRAME_BITS - 1; i++) sendBit(fr[i]);
    @(negedge clk) ps2_data = fr[10];
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    for (int c = 1; c <= 2 * H; c++) begin
      @(posedge clk); #1;
      if (c == H) ps2_clk = 1'b1;
      if (code_valid && lat < 0) lat = c;
    end
    modelFrame(8'h1C, 1'b0, 1'b1);
    nCmp++; if (lat != LAT) begin nErr++; $display("FAIL latency got %0d want %0d", lat, LAT); end
    nCmp++; if (code_out !== expCode) begin nErr++; $display("FAIL single_code got %h want %h", code_out, expCode); end
    nCmp++; if ({obsValid, obsPar, obsFrm} != {expValid, expPar, expFrm}) begin
      nErr++; $display("FAIL single_counts got %0d/%0d/%0d want %0d/%0d/%0d", obsValid, obsPar, obsFrm, expValid, expPar, expFrm);
    end
    $display("test_single_latency: code_out=%h latency=%0d", code_out, lat);
  endtask

  task automatic test_back_to_back;
    logic [7:0] codes [2];
    codes[0] = 8'hF0;
    codes[1] = 8'h75;
    for (int k = 0; k < 2; k++) begin
      sendFrame(codes[k], goodParity(codes[k]), 1'b1);
      modelFrame(codes[k], goodParity(codes[k]), 1'b1);
      nCmp++; if (code_out !== expCode) begin nErr++; $display("FAIL b2b_code%0d got %h want %h", k, code_out, expCode); end
      $display("test_back_to_back: frame %0d code_out=%h", k, code_out);
    end
    nCmp++; if ({obsValid, obsPar, obsFrm} != {expValid, expPar, expFrm}) begin
      nErr++; $display("FAIL b2b_counts got %0d/%0d/%0d want %0d/%0d/%0d", obsValid, obsPar, obsFrm, expValid, expPar, expFrm);
    end
  endtask

  task automatic test_parity_err;
    sendFrame(8'h1C, 1'b1, 1'b1);
    modelFrame(8'h1C, 1'b1, 1'b1);
    nCmp++; if (code_out !== 8'h75) begin nErr++; $display("FAIL parity_hold got %h want 75", code_out); end
    nCmp++; if ({obsValid, obsPar, obsFrm} != {expValid, expPar, expFrm}) begin
      nErr++; $display("FAIL parity_counts got %0d/%0d/%0d want %0d/%0d/%0d", obsValid, obsPar, obsFrm, expValid, expPar, expFrm);
    end
    $display("test_parity_err: code_out=%h parity_errs=%0d", code_out, obsPar);
  endtask

  task automatic test_timeout;
    int lat;
    logic [7:0] d;
    lat = -1;
    d = 8'h1C;
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(d[i]);
    @(negedge clk) ps2_data = d[3];
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    for (int c = 1; c <= LAT + T + 50 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (c == H) ps2_clk = 1'b1;
      if (frame_err) lat = c;
    end
    expFrm++;
    repeat (H) @(negedge clk);
    nCmp++; if (lat != LAT + T) begin nErr++; $display("FAIL timeout_delay got %0d want %0d", lat, LAT + T); end
    nCmp++; if (code_out !== expCode) begin nErr++; $display("FAIL timeout_hold got %h want %h", code_out, expCode); end
    sendFrame(8'h29, goodParity(8'h29), 1'b1);
    modelFrame(8'h29, goodParity(8'h29), 1'b1);
    nCmp++; if (code_out !== 8'h29) begin nErr++; $display("FAIL after_timeout_code got %h want 29", code_out); end
    nCmp++; if ({obsValid, obsPar, obsFrm} != {expValid, expPar, expFrm}) begin
      nErr++; $display("FAIL timeout_counts got %0d/%0d/%0d want %0d/%0d/%0d", obsValid, obsPar, obsFrm, expValid, expPar, expFrm);
    end
    $display("test_timeout: frame_err after %0d cycles, next code_out=%h", lat, code_out);
  endtask

  task automatic test_stop_and_false_start;
    sendFrame(8'h5A, goodParity(8'h5A), 1'b0);
    modelFrame(8'h5A, goodParity(8'h5A), 1'b0);
    sendBit(1'b1);
    repeat (H) @(negedge clk);
    nCmp++; if (code_out !== expCode) begin nErr++; $display("FAIL stop_hold got %h want %h", code_out, expCode); end
    nCmp++; if ({obsValid, obsPar, obsFrm} != {expValid, expPar, expFrm}) begin
      nErr++; $display("FAIL stop_counts got %0d/%0d/%0d want %0d/%0d/%0d", obsValid, obsPar, obsFrm, expValid, expPar, expFrm);
    end
    sendFrame(8'h33, goodParity(8'h33), 1'b1);
    modelFrame(8'h33, goodParity(8'h33), 1'b1);
    nCmp++; if (code_out !== 8'h33) begin nErr++; $display("FAIL after_false_start got %h want 33", code_out); end
    $display("test_stop_and_false_start: code_out=%h frame_errs=%0d", code_out, obsFrm);
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic p, s;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      p = goodParity(d) ^ ($urandom_range(3) == 0);
      s = ($urandom_range(5) == 0) ? 1'b0 : 1'b1;
      sendFrame(d, p, s);
      modelFrame(d, p, s);
      nCmp++; if (code_out !== expCode || {obsValid, obsPar, obsFrm} != {expValid, expPar, expFrm}) begin
        nErr++;
        $display("FAIL random%0d got %h %0d/%0d/%0d want %h %0d/%0d/%0d", n, code_out, obsValid, obsPar, obsFrm,
                 expCode, expValid, expPar, expFrm);
      end
      $display("test_random: frame %0d data=%h p=%b s=%b code_out=%h", n, d, p, s, code_out);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    d = 8'h1C;
    if (expCode == 8'h00) begin
      sendFrame(8'h29, goodParity(8'h29), 1'b1);
      modelFrame(8'h29, goodParity(8'h29), 1'b1);
    end
    sendBit(1'b0);
    for (int i = 0; i < 5; i++) sendBit(d[i]);
    @(negedge clk) resetn = 1'b0;
    #1;
    nCmp++; if ({code_out, code_valid, parity_err, frame_err} !== 11'h0) begin
      nErr++; $display("FAIL midreset_outputs got %h/%b%b%b want 00/000", code_out, code_valid, parity_err, frame_err);
    end
    expCode = 8'h00;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    sendFrame(8'h1C, goodParity(8'h1C), 1'b1);
    modelFrame(8'h1C, goodParity(8'h1C), 1'b1);
    nCmp++; if (code_out !== 8'h1C) begin nErr++; $display("FAIL midreset_recover got %h want 1C", code_out); end
    nCmp++; if ({obsValid, obsPar, obsFrm} != {expValid, expPar, expFrm}) begin
      nErr++; $display("FAIL midreset_counts got %0d/%0d/%0d want %0d/%0d/%0d", obsValid, obsPar, obsFrm, expValid, expPar, expFrm);
    end
    $display("test_reset_midframe: code_out=%h", code_out);
  endtask

`ifdef PS2_GLITCH_FILTER_EN
  task automatic test_glitch;
    @(negedge clk) ps2_data = 1'b0;
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2 * H) @(negedge clk);
    sendFrame(8'h4B, goodParity(8'h4B), 1'b1);
    modelFrame(8'h4B, goodParity(8'h4B), 1'b1);
    nCmp++; if (code_out !== 8'h4B || {obsValid, obsPar, obsFrm} != {expValid, expPar, expFrm}) begin
      nErr++; $display("FAIL glitch got %h %0d/%0d/%0d want 4B %0d/%0d/%0d", code_out, obsValid, obsPar, obsFrm,
                       expValid, expPar, expFrm);
    end
    $display("test_glitch: code_out=%h", code_out);
  endtask
`endif

  initial begin
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_parity_err();
    test_timeout();
    test_stop_and_false_start();
    test_random();
    test_reset_midframe();
`ifdef PS2_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
